// File: rtl/mod_reduce_ctrl.sv
// 64-bit restoring shift-and-subtract reducer: remainder and quotient,
// one bit per clock on a single shared ripple subtractor.
module fullsubtractor (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] diff_o
);
  logic bw;

  always_comb begin
    diff_o = '0;
    bw     = 1'b0;
    for (int i = 0; i < 64; i++) begin
      diff_o[i] = a_i[i] ^ b_i[i] ^ bw;
      bw = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw);
    end
  end
endmodule

module mod_reduce_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient,
  output logic             div_zero
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   rs;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;

  // D is consumed MSB-first, so the current bit is always d_q's top bit
  assign rs = {r_q, d_q[WIDTH-1]};
  assign ge = rs[WIDTH] | (rs[WIDTH-1:0] >= n_q);

  fullsubtractor u_sub (
    .a_i   (rs[WIDTH-1:0]),
    .b_i   (n_q),
    .diff_o(diff)
  );

  assign r_d = ge ? diff : rs[WIDTH-1:0];
  assign q_d = {q_q[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      d_q       <= '0;
      n_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remainder <= '0;
      quotient  <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (modulus != '0) begin
              d_q     <= dividend;
              n_q     <= modulus;
              r_q     <= '0;
              q_q     <= '0;
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= RUN;
            end else begin
              remainder <= dividend;
              quotient  <= '1;
              div_zero  <= 1'b1;
              done      <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          d_q <= {d_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            remainder <= r_d;
            quotient  <= q_d;
            div_zero  <= 1'b0;
            done      <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_reduce_ctrl.sv
// Self-checking bench for mod_reduce_ctrl: directed cases plus
// random operands against a % and / reference.
module tb_mod_reduce_ctrl;
  logic        clk;
  logic        reset_n;
  logic        start;
  logic [63:0] dividend;
  logic [63:0] modulus;
  logic        busy;
  logic        done;
  logic [63:0] remainder;
  logic [63:0] quotient;
  logic        div_zero;

  int n_vec;
  int n_err;

  mod_reduce_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dividend (dividend),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .remainder(remainder),
    .quotient (quotient),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v >> $urandom_range(63, 0);
  endfunction

  task automatic run_op(input logic [63:0] dvd, input logic [63:0] mdl,
                        input string tag);
    logic [63:0] er;
    logic [63:0] eq;
    logic        ez;
    int          lat;
    int          c;
    int          nb;
    bit          seen;
    if (mdl == 64'd0) begin
      er = dvd; eq = '1; ez = 1'b1; lat = 1;
    end else begin
      er = dvd % mdl; eq = dvd / mdl; ez = 1'b0; lat = 65;
    end
    @(negedge clk);
    start = 1'b1; dividend = dvd; modulus = mdl;
    @(negedge clk);
    start = 1'b0; dividend = ~dvd; modulus = {$urandom(), $urandom()};
    c = 1; nb = 0; seen = 1'b0;
    while (c < 200) begin
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_lat"}, 64'(c), 64'(lat));
      chk({tag, "_busy_cyc"}, 64'(nb), 64'(lat));
      chk({tag, "_rem"}, remainder, er);
      chk({tag, "_quo"}, quotient, eq);
      chk({tag, "_dz"}, 64'(div_zero), 64'(ez));
      @(negedge clk);
      chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
      chk({tag, "_rem_hold"}, remainder, er);
    end
  endtask

  task automatic ignore_test();
    int pulses;
    int dc;
    logic [63:0] r;
    logic [63:0] q;
    pulses = 0; dc = 1000; r = '0; q = '0;
    @(negedge clk);
    start = 1'b1; dividend = 64'd100; modulus = 64'd7;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      if (c == 10) begin
        start = 1'b1; dividend = 64'd50; modulus = 64'd3;
      end else if (c == 11) begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          r = remainder; q = quotient; dc = c;
          start = 1'b1; dividend = 64'd50; modulus = 64'd3;
        end
      end else if (c == dc + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_lat", 64'(dc), 64'd65);
    chk("ign_rem", r, 64'd2);
    chk("ign_quo", q, 64'd14);
    chk("ign_idle", {62'd0, busy, done}, 64'd0);
  endtask

  task automatic reset_test();
    int stray;
    @(negedge clk);
    start = 1'b1; dividend = 64'd100; modulus = 64'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rem", remainder, 64'd0);
    chk("rst_quo", quotient, 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (80) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk("rst_no_done", 64'(stray), 64'd0);
    run_op(64'd77, 64'd10, "r77_10");
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; start = 1'b0;
    dividend = '0; modulus = '0;
    repeat (3) @(negedge clk);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_done", 64'(done), 64'd0);
    chk("init_rem", remainder, 64'd0);
    chk("init_quo", quotient, 64'd0);
    chk("init_dz", 64'(div_zero), 64'd0);
    reset_n = 1'b1;

    run_op(64'd100, 64'd7, "d100_7");
    run_op('1, 64'hFFFF_FFFF_FFFF_FFFE, "dmax_fe");
    run_op('1, 64'h8000_0000_0000_0001, "dmax_8001");
    run_op(64'd5, 64'd9, "d5_9");
    run_op(64'd0, 64'd3, "d0_3");
    run_op(64'h1234, 64'd0, "dz");
    run_op(64'd100, 64'd7, "dz_clear");
    ignore_test();
    reset_test();

    for (int i = 0; i < 1000; i++) begin
      logic [63:0] a;
      logic [63:0] m;
      a = rnd64();
      m = rnd64();
      if (m == 64'd0) m = 64'd1;
      run_op(a, m, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
